gate_sweep_ctrl: RTL
====================

Name: gate_sweep_ctrl

Overview:
- Self-checking stimulus sequencer for the small combinational gate blocks in this codebase (2-input AND and the like).
- Drives every input combination of an N-input gate-under-test, waits a settle time, samples the gate output and compares it against an expected truth table.
- Reports pass/fail, the error count and the first failing vector.
- Sits beside the gate instance, in a bench or a BIST wrapper, in place of hand-written delay-sequenced stimulus.

Parameters:
- N_IN, 2, number of gate inputs; legal 1..8.
- SETTLE, 1, clock cycles each vector is held before the output is sampled; legal values are 1 or more.
- EXP_TT, 4'b1000, expected truth table of width 2**N_IN. Bit i is the expected gate output for input vector value i. The default is 2-input AND.

Ports:
- clk  input  1  clock; all logic is on the rising edge.
- rst  input  1  synchronous reset, active-high.
- start  input  1  one-cycle request to begin a sweep; accepted only in IDLE.
- vec  output  N_IN  registered stimulus to the gate; vec[k] drives gate input k.
- y_in  input  1  gate-under-test output.
- busy  output  1  high while a sweep is in progress.
- done  output  1  one-cycle pulse at the end of a sweep.
- pass  output  1  1 when the last sweep had zero mismatches; valid from done until the next accepted start.
- err_cnt  output  N_IN+1  number of mismatching vectors in the last sweep.
- fail_seen  output  1  at least one mismatch has occurred in the current or last sweep.
- first_fail  output  N_IN  vector value of the first mismatch; valid when fail_seen=1.

Behaviour:
- Reset (rst=1 at a clock edge):
  - state goes to IDLE.
  - vec, busy, done, pass, err_cnt, fail_seen and first_fail all go to 0.
  - Reset has priority over every other event, including mid-sweep. The sweep is abandoned and there is no done pulse.
- States: IDLE, RUN, DONE.
- IDLE:
  - vec is held at 0.
  - If start=1 at an edge: go to RUN, busy=1, vec=0, settle counter=0, err_cnt=0, fail_seen=0, first_fail=0, pass=0.
- RUN:
  - The settle counter increments at each edge.
  - At the edge where the counter equals SETTLE-1, this is the sample edge:
    - y_in is compared with EXP_TT[vec].
    - On mismatch: err_cnt increments. If fail_seen=0, first_fail is set to vec and fail_seen is set to 1.
    - If vec is not all-ones: vec increments and the counter goes back to 0.
    - If vec is all-ones: go to DONE. vec returns to 0, busy=0, done=1, and pass is computed including the final comparison.
  - Each vector is held for exactly SETTLE cycles.
  - Done rises exactly 2**N_IN * SETTLE edges after the start-accept edge.
- DONE:
  - Lasts one cycle, then returns to IDLE with done=0.
  - start is ignored in DONE and in RUN; there is no queuing.
- Result hold: pass, err_cnt, fail_seen and first_fail hold their values until the next accepted start or a reset.
- Width rule: err_cnt is N_IN+1 bits, so the maximum count 2**N_IN cannot overflow and no saturation is needed.
- Sampling: y_in is sampled only at sample edges. Glitches on y_in between sample edges are ignored.

Optional Feature:
- Macro: GATE_SWEEP_STOP_ON_FAIL_EN.
- Defined: the first mismatch ends the sweep at its sample edge. The block goes to DONE with done=1, busy=0, pass=0, err_cnt=1, and vec returns to 0. The remaining vectors are not driven.
- Undefined: the sweep always covers all 2**N_IN vectors and counts every mismatch.

Test Plan:
- Defaults with a correct AND gate; start pulse at edge 0 -> vec steps 0,1,2,3, one per cycle. done pulses after edge 4, pass=1, err_cnt=0, fail_seen=0.
- Defaults with an OR gate wired in -> mismatches at vectors 1 and 2. At done: pass=0, err_cnt=2, first_fail=2'b01, fail_seen=1.
- SETTLE=3 with a correct AND gate -> each vec value is held 3 cycles. done comes 12 edges after start-accept; busy is high for 12 cycles; pass=1.
- start re-pulsed during RUN and again during the DONE cycle -> both are ignored and the single sweep timing is unchanged. A start in the following IDLE cycle begins a new sweep and clears err_cnt/pass.
- rst asserted during the 3rd vector of a sweep -> next cycle busy=0, vec=0, err_cnt=0, no done pulse. A subsequent start sweeps normally.
- GATE_SWEEP_STOP_ON_FAIL_EN defined, OR gate wired in -> done 2 edges after start-accept, err_cnt=1, first_fail=2'b01, pass=0. With the macro undefined the result is as in scenario 2.

Source files
------------

// File: rtl/gate_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// gate_sweep_ctrl
//
// Exhaustive stimulus sequencer and checker for a small combinational gate.
// It drives every input combination of an N_IN-input gate, holds each
// combination for SETTLE cycles, samples the gate output on the last cycle of
// the hold and compares it with the expected truth table EXP_TT.
//
// Parameters:
//   N_IN    number of gate inputs (1..8)
//   SETTLE  cycles each vector is held before sampling (>= 1)
//   EXP_TT  expected truth table, bit i = expected output for input value i
//
// Ports:
//   clk         clock, rising edge
//   rst         synchronous reset, active-high, highest priority
//   start       one-cycle sweep request, honoured only in IDLE
//   vec         registered stimulus to the gate (vec[k] -> gate input k)
//   y_in        gate-under-test output
//   busy        high while a sweep is in progress
//   done        one-cycle pulse at the end of a sweep
//   pass        last sweep had no mismatches (valid from done to next start)
//   err_cnt     number of mismatching vectors in the last sweep
//   fail_seen   at least one mismatch in the current / last sweep
//   first_fail  vector value of the first mismatch (valid when fail_seen)
//
// Build option:
//   GATE_SWEEP_STOP_ON_FAIL_EN  when defined, the first mismatch ends the
//                               sweep at its sample edge.
// -----------------------------------------------------------------------------
module gate_sweep_ctrl #(
  parameter int                   N_IN   = 2,
  parameter int                   SETTLE = 1,
  parameter logic [(1<<N_IN)-1:0] EXP_TT = 4'b1000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic [N_IN-1:0] vec,
  input  logic            y_in,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_cnt,
  output logic            fail_seen,
  output logic [N_IN-1:0] first_fail
);

  // The settle counter only has to reach SETTLE-1.
  localparam int              CNT_W    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [N_IN-1:0]  vec_q, vec_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [N_IN:0]    err_q, err_d;
  logic             fs_q, fs_d;
  logic [N_IN-1:0]  ff_q, ff_d;

  logic             sample_edge;
  logic             mismatch;
  logic             vec_last;
  logic             end_sweep;

  assign sample_edge = (cnt_q == CNT_LAST);
  assign mismatch    = (y_in != EXP_TT[vec_q]);
  assign vec_last    = &vec_q;

  // A sweep ends after the last vector, or optionally at the first mismatch.
`ifdef GATE_SWEEP_STOP_ON_FAIL_EN
  assign end_sweep = vec_last | mismatch;
`else
  assign end_sweep = vec_last;
`endif

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    err_d   = err_q;
    fs_d    = fs_q;
    ff_d    = ff_q;

    case (state_q)
      S_IDLE: begin
        vec_d  = '0;
        busy_d = 1'b0;
        if (start) begin
          state_d = S_RUN;
          busy_d  = 1'b1;
          cnt_d   = '0;
          err_d   = '0;
          fs_d    = 1'b0;
          ff_d    = '0;
          pass_d  = 1'b0;
        end
      end

      S_RUN: begin
        if (sample_edge) begin
          if (mismatch) begin
            err_d = err_q + {{N_IN{1'b0}}, 1'b1};
            if (!fs_q) begin
              ff_d = vec_q;
              fs_d = 1'b1;
            end
          end
          cnt_d = '0;
          if (end_sweep) begin
            // pass reflects the count including this final comparison
            state_d = S_DONE;
            vec_d   = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (err_d == '0);
          end else begin
            vec_d = vec_q + {{(N_IN-1){1'b0}}, 1'b1};
          end
        end else begin
          cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end

      S_DONE: begin
        // start is deliberately ignored here; no request queuing
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = S_IDLE;
        vec_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      vec_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      fs_q    <= 1'b0;
      ff_q    <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      fs_q    <= fs_d;
      ff_q    <= ff_d;
    end
  end

  assign vec        = vec_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_cnt    = err_q;
  assign fail_seen  = fs_q;
  assign first_fail = ff_q;

endmodule
